// File: rtl/fetch_queue_if.sv
// Fetch-queue handshake bundle: redirect input, imem request/response channel, decode-side output.
// master = fetch_queue side, slave = memory/execute/decode environment side.
interface fetch_queue_if;
  logic        branch_sel;
  logic [31:0] branch_inp;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc_present;
  logic [31:0] pc_next;
  logic [31:0] bubble_cnt;

  modport master (
    input  branch_sel, branch_inp, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
    output imem_req_valid, imem_req_addr, inst_valid, inst, pc_present, pc_next, bubble_cnt
  );

  modport slave (
    output branch_sel, branch_inp, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
    input  imem_req_valid, imem_req_addr, inst_valid, inst, pc_present, pc_next, bubble_cnt
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front-end: in-order imem requests, DEPTH-entry {pc,inst} FIFO, branch flush.
// Define FETCH_QUEUE_PERF_EN to build the bubble_cnt stall counter; otherwise bubble_cnt is 0.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic         clk,
  input logic         reset,
  fetch_queue_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, outstanding, drop_cnt;

  logic [CW:0]   budget;
  logic          req_valid, req_fire, rsp_take, push, pop, not_empty, inst_valid;
  logic [31:0]   rsp_pc;
  logic          unused_bits;

  assign unused_bits = ^bus.branch_inp[1:0];

  always_comb begin
    budget     = {1'b0, count} + {1'b0, outstanding};
    req_valid  = !reset && !bus.branch_sel && (budget < LIMIT);
    req_fire   = req_valid && bus.imem_req_ready;
    rsp_take   = bus.imem_rsp_valid && (outstanding != '0);
    push       = rsp_take && (drop_cnt == '0) && !bus.branch_sel;
    not_empty  = (count != '0);
    inst_valid = not_empty && !bus.branch_sel;
    pop        = inst_valid && bus.inst_ready;
    // Once drops are drained, every outstanding request is a consecutive fetch
    // ending at fetch_pc-4, so the oldest one's PC falls out of the counter.
    rsp_pc     = fetch_pc - 32'({outstanding, 2'b00});
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.inst_valid     = inst_valid;
  assign bus.inst           = not_empty ? data_q[rd_ptr] : '0;
  assign bus.pc_present     = not_empty ? pc_q[rd_ptr]   : '0;
  assign bus.pc_next        = bus.pc_present + 32'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
      if (bus.branch_sel) begin
        // Everything still in flight after this edge belongs to the old path.
        fetch_pc <= {bus.branch_inp[31:2], 2'b00};
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        drop_cnt <= outstanding - CW'(rsp_take);
      end else begin
        if (req_fire)
          fetch_pc <= fetch_pc + 32'd4;
        if (rsp_take && (drop_cnt != '0))
          drop_cnt <= drop_cnt - CW'(1);
        if (push)
          wr_ptr <= wr_ptr + AW'(1);
        if (pop)
          rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr] <= bus.imem_rsp_data;
      pc_q[wr_ptr]   <= rsp_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      assert (!(bus.imem_rsp_valid && (outstanding == '0)));
  end

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] bubble_q;

  always_ff @(posedge clk) begin
    if (reset)
      bubble_q <= '0;
    else if (bus.inst_ready && !inst_valid && (bubble_q != '1))
      bubble_q <= bubble_q + 32'd1;
  end

  assign bus.bubble_cnt = bubble_q;
`else
  assign bus.bubble_cnt = '0;
`endif
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch front-end. Sits upstream of the decode stage and supplies the instruction word plus its PC.
- Issues in-order requests to an instruction memory over a valid/ready request channel and accepts responses.
- Buffers fetched instructions in a small FIFO and hands them downstream with a valid/ready handshake.
- Accepts branch redirects from execute: flushes the buffer and discards stale in-flight responses.

Parameters:
- DEPTH, 4, FIFO entries and maximum outstanding requests; power of two, ≥2.
- RESET_PC, 32'h0000_0000, first fetch address after reset; word-aligned.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- branch_sel  in  1  redirect request from execute.
- branch_inp  in  32  redirect target; bits [1:0] ignored (forced 0).
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  request word address (byte address, [1:0]=0).
- imem_rsp_valid  in  1  response data valid; responses are in order, latency ≥1 cycle.
- imem_rsp_data  in  32  instruction word.
- inst_valid  out  1  head entry valid toward decode.
- inst_ready  in  1  decode consumes head.
- inst  out  32  head instruction.
- pc_present  out  32  PC of head instruction.
- pc_next  out  32  pc_present + 4, wraps modulo 2^32.
- bubble_cnt  out  32  perf counter (see Optional Feature).

Behaviour:
- Reset (sync, highest priority): fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0. Outputs: imem_req_valid=0, inst_valid=0, inst=0, pc_present=0, pc_next=4, bubble_cnt=0. Reset asserted mid-operation discards everything, including in-flight responses. Any response after reset with outstanding=0 is ignored.
- Request issue: imem_req_valid = !reset && !branch_sel && (occupancy + outstanding < DEPTH). imem_req_addr=fetch_pc.
  - On request handshake: fetch_pc += 4 (mod 2^32) and outstanding increments.
- Response:
  - Each imem_rsp_valid with outstanding>0 decrements outstanding.
  - If drop_cnt>0, the response is discarded and drop_cnt decrements.
  - Otherwise {pc, data} is pushed to the FIFO; the pc comes from a shadow PC queue/counter that tracks the issue order.
  - The FIFO never overflows, guaranteed by the issue rule.
- Output: inst_valid = FIFO non-empty && !branch_sel. inst/pc_present show the head entry. On inst_valid && inst_ready the head is popped.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
- Latency: with a 1-cycle memory and empty FIFO, the first instruction is valid 2 cycles after reset deasserts. Steady-state throughput is 1 instruction/cycle.
- Redirect (branch_sel=1 in cycle t):
  - No request is issued and no instruction is presented in cycle t.
  - At edge t: FIFO cleared, fetch_pc = {branch_inp[31:2],2'b00}, drop_cnt = outstanding − (response arriving in t ? 1 : 0) + drop_cnt adjustments. Net effect: all requests issued before t are dropped.
  - The first request to the new target is issued at t+1.
  - Back-to-back redirects: the last one wins; drops accumulate correctly.
- Counter widths: occupancy, outstanding and drop_cnt are $clog2(DEPTH)+1 bits; none exceeds DEPTH.
- Pointer wrap: FIFO read/write pointers wrap modulo DEPTH.
- Protocol violation: a response with outstanding=0 is ignored (simulation assertion fires).

Optional Feature:
- Macro FETCH_QUEUE_PERF_EN.
- Defined: bubble_cnt increments (saturating at 32'hFFFF_FFFF) each cycle with inst_ready=1 && inst_valid=0 && !reset; reset clears it.
- Undefined: bubble_cnt is tied to 0 and no counter logic is generated.

Test Plan:
- Reset release, memory with 1-cycle latency and always-ready, inst_ready=1 → requests at 0x0,0x4,0x8…; inst_valid at cycle 2 with pc_present=0x0, pc_next=0x4; then one instruction per cycle.
- inst_ready=0 for 10 cycles, DEPTH=4 → exactly 4 requests outstanding/buffered, imem_req_valid drops to 0, no data loss. On release, instructions pop in order 0x0..0xC.
- 3-cycle memory latency, 3 requests in flight, branch_sel pulse with branch_inp=0x0000_0103 → next request addr 0x100. The 3 stale responses are discarded. First delivered inst has pc_present=0x100.
- Redirect in the same cycle as a response arrives, then a second redirect to 0x200 one cycle later → no stale instruction delivered; first output pc_present=0x200.
- fetch_pc at 0xFFFF_FFFC → next request addr 0x0000_0000; pc_next for that head = 0x0.
- FETCH_QUEUE_PERF_EN defined, memory stalled (imem_req_ready=0) 7 cycles with inst_ready=1 and FIFO empty → bubble_cnt=7. Undefined → bubble_cnt stays 0.
